// File: rtl/arbiter_rr.sv
// N-channel round-robin arbiter with registered one-hot grant and zero-bubble hand-over.
// Optional burst limit enabled by defining ARBITER_RR_BURST_LIMIT_EN.
//
// state    | meaning
// IDLE     | gnt == 0, no owner
// OWNED(i) | gnt[i] == 1, requester i owns the resource
module arbiter_rr #(
    parameter int N         = 4,
    parameter int IDW       = $clog2(N),
    parameter int MAX_BURST = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    logic [IDW-1:0] last;
    logic [IDW-1:0] last_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [IDW-1:0] gnt_id_nxt;
    logic           gnt_valid_nxt;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] idx;
    logic           pick_found;
    logic           hold;
    logic           expire;

`ifdef ARBITER_RR_BURST_LIMIT_EN
    localparam logic [7:0] CNT_SAT = 8'(MAX_BURST - 1);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    // Owner is forced out only once saturated and someone else is waiting.
    assign expire = (cnt == CNT_SAT) && (|(req & ~gnt));
`else
    assign expire = 1'b0;
`endif

    assign hold = (|(gnt & req)) && !expire;

    // Search starts just past the last owner, so the last owner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(last) + k) % N);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        last_nxt      = last;
`ifdef ARBITER_RR_BURST_LIMIT_EN
        cnt_nxt       = cnt;
`endif
        if (hold) begin
`ifdef ARBITER_RR_BURST_LIMIT_EN
            if (cnt != CNT_SAT) begin
                cnt_nxt = cnt + 8'd1;
            end
`endif
        end else if (pick_found) begin
            gnt_nxt           = '0;
            gnt_nxt[pick_idx] = 1'b1;
            gnt_id_nxt        = pick_idx;
            gnt_valid_nxt     = 1'b1;
            last_nxt          = pick_idx;
`ifdef ARBITER_RR_BURST_LIMIT_EN
            cnt_nxt           = 8'd0;
`endif
        end else begin
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            last      <= IDW'(N - 1);
        end else begin
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            last      <= last_nxt;
        end
    end

`ifdef ARBITER_RR_BURST_LIMIT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr (N=4, MAX_BURST=3); expected grants are queued
// as requests are driven and compared after the following rising edge.
module tb_arbiter_rr;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int checks = 0;
    int passed = 0;
    logic [3:0] exp_q[$];

    arbiter_rr #(.N(4), .MAX_BURST(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    // Drive one request vector, queue the grant expected after the next edge.
    task automatic cycle(input logic [3:0] r, input logic [3:0] e);
        @(negedge clock);
        req = r;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b0000;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        reset = 1'b0;
        req   = 4'b1111;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
            $display("FAIL reset_hold: gnt=%b id=%0d valid=%b, expected gnt=0000 id=0 valid=0", gnt, gnt_id, gnt_valid);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(4'b0001);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e || gnt_valid !== (|e) || gnt_id !== onehot_idx(e))
            $display("FAIL reset_first: gnt=%b id=%0d valid=%b, expected gnt=%b", gnt, gnt_id, gnt_valid, e);
        else passed++;
    endtask

    task automatic test_single();
        logic [3:0] rq[7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic [3:0] ex[7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic [3:0] e;
        for (int i = 0; i < 7; i++) begin
            cycle(rq[i], ex[i]);
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e || gnt_valid !== (|e) || ((|e) && gnt_id !== onehot_idx(e)))
                $display("FAIL single[%0d]: gnt=%b id=%0d valid=%b, expected gnt=%b", i, gnt, gnt_id, gnt_valid, e);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rq[9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                              4'b1111, 4'b1011, 4'b1111, 4'b0111};
        logic [3:0] ex[9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                              4'b0100, 4'b1000, 4'b1000, 4'b0001};
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(rq[i], ex[i]);
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e || gnt_valid !== (|e) || ((|e) && gnt_id !== onehot_idx(e)))
                $display("FAIL round_robin[%0d]: gnt=%b id=%0d valid=%b, expected gnt=%b", i, gnt, gnt_id, gnt_valid, e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rq[5] = '{4'b1000, 4'b1001, 4'b0001, 4'b0000, 4'b0001};
        logic [3:0] ex[5] = '{4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0001};
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(rq[i], ex[i]);
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e || gnt_valid !== (|e) || ((|e) && gnt_id !== onehot_idx(e)))
                $display("FAIL handover[%0d]: gnt=%b id=%0d valid=%b, expected gnt=%b", i, gnt, gnt_id, gnt_valid, e);
            else passed++;
        end
    endtask

    task automatic test_burst();
`ifdef ARBITER_RR_BURST_LIMIT_EN
        logic [3:0] ex[16] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        logic [3:0] ex[16] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        logic [3:0] rq[16] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                               4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0011};
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(rq[i], ex[i]);
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e || gnt_valid !== (|e) || ((|e) && gnt_id !== onehot_idx(e)))
                $display("FAIL burst[%0d]: gnt=%b id=%0d valid=%b, expected gnt=%b", i, gnt, gnt_id, gnt_valid, e);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] e;
        do_reset();
        cycle(4'b0100, 4'b0100);
        cycle(4'b0100, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e || gnt_valid !== (|e) || gnt_id !== onehot_idx(e))
                $display("FAIL mid_pre[%0d]: gnt=%b id=%0d valid=%b, expected gnt=%b", i, gnt, gnt_id, gnt_valid, e);
            else passed++;
        end
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b0110;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
            $display("FAIL mid_async_clear: gnt=%b id=%0d valid=%b, expected gnt=0000 id=0 valid=0", gnt, gnt_id, gnt_valid);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0)
            $display("FAIL mid_in_reset: gnt=%b valid=%b, expected gnt=0000 valid=0", gnt, gnt_valid);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(4'b0010);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e || gnt_valid !== (|e) || gnt_id !== onehot_idx(e))
            $display("FAIL mid_restart: gnt=%b id=%0d valid=%b, expected gnt=%b", gnt, gnt_id, gnt_valid, e);
        else passed++;
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_burst();
        test_reset_mid_grant();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/arbiter_rr.md
# arbiter_rr

Parametrised N-channel round-robin arbiter and the successor to the two-requester `arbiter`. Grants one of N requesters a single shared resource with a registered one-hot grant. The grant is held while the owner keeps requesting, and hand-over to the next requester takes no idle cycle. An optional burst limit bounds how long one owner can hold the grant while others wait.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `IDW`, default `$clog2(N)`: width of `gnt_id`; derived, never overridden.
- `MAX_BURST`, default 8: maximum consecutive grant cycles while another requester waits; legal range 1..255; used only with `ARBITER_RR_BURST_LIMIT_EN`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in N: request per channel; level-sensitive; bit i belongs to requester i.
- `gnt` out N: one-hot grant, or all-zero; registered.
- `gnt_id` out IDW: index of the granted channel; valid only when `gnt_valid`=1.
- `gnt_valid` out 1: registered OR of `gnt`.

## Operation
- State registers:
  - `gnt`.
  - `last`: index of the most recent owner, IDW bits.
  - `cnt`: burst count, 8 bits, present only with the macro.
- On reset assertion, immediately and asynchronously:
  - `gnt`=0, `gnt_id`=0, `gnt_valid`=0.
  - `last`=N-1, so channel 0 wins the first arbitration.
  - `cnt`=0.
- Effective states:
  - IDLE: `gnt`=0.
  - OWNED(i): `gnt[i]`=1.
- Each rising edge, evaluated in priority order:
  1. OWNED(i), `req[i]`=1, and no burst expiry: stay OWNED(i).
  2. Otherwise, search `req` from index (`last`+1) mod N upward with wrap-around. The first set bit j becomes the owner: OWNED(j), `last`=j, `cnt`=0.
  3. No bit set: IDLE; `last` unchanged.
- When the owner drops `req` and others are requesting, the next owner is granted on the same edge. There is no bubble cycle.
- A released owner can be regranted only after every other asserted requester has been considered. If it is the sole requester, it is regranted immediately.
- `gnt_id` and `gnt_valid` are registered together with `gnt` and are always mutually consistent.
- Changes on `req` between edges have no effect until the next edge.

## Timing
- Latency: a `req` rise sampled at edge k from IDLE gives `gnt` high after edge k, so it is visible in cycle k+1.
- Release: `req[i]` low sampled at edge k gives `gnt[i]` low after edge k.
- Reset deassertion is synchronised externally. The first arbitration happens on the first edge with `reset`=1.
- Reset asserted mid-grant: outputs clear immediately without waiting for a clock edge. After release, arbitration restarts from channel 0.
- Maximum wait, with the macro: (N-1)·`MAX_BURST` cycles from request to grant. Without the macro the wait is unbounded, because an owner may hold the grant indefinitely.

## Configuration
- Macro `ARBITER_RR_BURST_LIMIT_EN` enables the burst limit.
- Defined:
  - `cnt` increments on each edge where the owner is retained.
  - `cnt` saturates at `MAX_BURST`-1.
  - When `cnt`=`MAX_BURST`-1 and any other `req` bit is set, the next edge forces re-arbitration starting at `last`+1. The owner loses the grant even though its `req` is still 1.
  - If no other requester is active, the owner keeps the grant and `cnt` stays saturated.
  - `MAX_BURST`=1 makes the arbiter rotate every cycle under contention.
- Undefined:
  - No counter logic is built and `MAX_BURST` is ignored.
  - The owner keeps the grant for as long as its `req` stays high.

## Test plan
- Reset with `req`=4'b1111, N=4:
  - During reset: `gnt`=0, `gnt_valid`=0.
  - First edge after release: `gnt`=4'b0001, `gnt_id`=0.
- `req`=4'b0100 alone, held 5 cycles then dropped:
  - `gnt`=4'b0100 for 5 cycles starting one cycle after the request.
  - Then `gnt`=0 and `gnt_valid`=0.
- Round robin, all four requesting, each owner dropping `req` for one cycle after 2 granted cycles:
  - Grant order 0,1,2,3,0.
  - No cycle with `gnt`=0 during the sequence.
- Hand-over with `req`=4'b1001 and owner 3 releasing:
  - Next edge: `gnt`=4'b0001, wrapping from `last`=3 to 0, with no idle cycle.
- Burst limit, macro defined, `MAX_BURST`=3:
  - `req`=4'b0011 held constant.
  - `gnt` alternates 0001,0001,0001,0010,0010,0010,0001,...
  - With `req`=4'b0001 only, `gnt`=4'b0001 stays indefinitely.
- Reset asserted mid-grant while `gnt`=4'b0100:
  - `gnt`=0 before the next edge.
  - After release with `req`=4'b0110, `gnt`=4'b0010, because the pointer was reset.
